// File: rtl/seg7_pkg.sv
// Shared definitions for the four-digit seven-segment scan driver.
// Holds the active-low segment codes ({g,f,e,d,c,b,a}, dp excluded),
// the blank code and the per-slot scan state encoding.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h0E;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // GAP blanks the start of a digit slot to avoid ghosting; SHOW drives it.
  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// CPU-side load port of the seven-segment driver.
//   data_in    : 16-bit hex value, digit k = data_in[4k+3:4k]
//   dp_in      : decimal-point mask, bit k = digit k, 1 = lit
//   data_valid : single-cycle strobe capturing data_in/dp_in
// master = CPU side (drives), slave = display driver (receives).
interface seg7_scan_driver_if;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        data_valid;

  modport master (output data_in, output dp_in, output data_valid);
  modport slave  (input  data_in, input  dp_in, input  data_valid);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment code.
//   nibble : 4-bit hex digit
//   code_c : {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] code_c
);

  always_comb begin
    code_c = SEG_BLANK;
    case (nibble)
      4'h0: code_c = SEG_HEX_0;
      4'h1: code_c = SEG_HEX_1;
      4'h2: code_c = SEG_HEX_2;
      4'h3: code_c = SEG_HEX_3;
      4'h4: code_c = SEG_HEX_4;
      4'h5: code_c = SEG_HEX_5;
      4'h6: code_c = SEG_HEX_6;
      4'h7: code_c = SEG_HEX_7;
      4'h8: code_c = SEG_HEX_8;
      4'h9: code_c = SEG_HEX_9;
      4'hA: code_c = SEG_HEX_A;
      4'hB: code_c = SEG_HEX_B;
      4'hC: code_c = SEG_HEX_C;
      4'hD: code_c = SEG_HEX_D;
      4'hE: code_c = SEG_HEX_E;
      4'hF: code_c = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver.
// Captures a hex value + dp mask into a pending register and applies it to
// the display only at frame boundaries, so a frame never shows a torn value.
// Each digit slot is SCAN_DIV cycles; the first GAP_CYC are blanked.
//   clk_100mhz : system clock
//   rst        : synchronous active-high reset
//   bus        : seg7_scan_driver_if.slave (data_in, dp_in, data_valid)
//   AN         : digit enables, active-low, registered
//   SEGMENT    : {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_done : one-cycle pulse after the last cycle of digit 3's slot
// Build option: define SEG7_LZ_BLANK_EN for leading-zero suppression
// (digits 3..1 blank while they and all higher digits are zero).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned GAP_CYC  = 2000
)(
  input  logic                clk_100mhz,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus,
  output logic [3:0]          AN,
  output logic [7:0]          SEGMENT,
  output logic                frame_done
);

  localparam int unsigned      CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [3:0]       an_d;
  logic [7:0]       seg_d;
  logic             fd_d;

  logic [15:0]      pend_data, disp_data;
  logic [3:0]       pend_dp, disp_dp;
  logic             pend_flag;

  logic             slot_end_c, frame_end_c;
  logic [3:0]       nib_c;
  logic [SEG_W-1:0] hex_code_c;
  logic             lz_blank_c;

  assign slot_end_c  = (cnt_q == CNT_MAX);
  assign frame_end_c = slot_end_c && (dig_q == 2'd3);

  // Nibble of the digit currently being scanned.
  always_comb begin
    nib_c = disp_data[3:0];
    case (dig_q)
      2'd0: nib_c = disp_data[3:0];
      2'd1: nib_c = disp_data[7:4];
      2'd2: nib_c = disp_data[11:8];
      2'd3: nib_c = disp_data[15:12];
    endcase
  end

  seg7_hex_decode u_hex_decode (
    .nibble (nib_c),
    .code_c (hex_code_c)
  );

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    lz_blank_c = 1'b0;
    case (dig_q)
      2'd3:    lz_blank_c = (disp_data[15:12] == 4'h0);
      2'd2:    lz_blank_c = (disp_data[15:8]  == 8'h00);
      2'd1:    lz_blank_c = (disp_data[15:4]  == 12'h000);
      default: lz_blank_c = 1'b0;
    endcase
  end
`else
  assign lz_blank_c = 1'b0;
`endif

  // Scan state register plus registered pin outputs.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= GAP;
      cnt_q      <= '0;
      dig_q      <= 2'd0;
      AN         <= 4'hF;
      SEGMENT    <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      AN         <= an_d;
      SEGMENT    <= seg_d;
      frame_done <= fd_d;
    end
  end

  // Next slot position / state, and next pin values from the current state.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    dig_d   = dig_q;
    state_d = state_q;
    an_d    = 4'hF;
    seg_d   = 8'hFF;
    fd_d    = frame_end_c;

    if (slot_end_c) begin
      cnt_d   = '0;
      dig_d   = dig_q + 2'd1;
      state_d = (GAP_CYC == 0) ? SHOW : GAP;
    end else if (32'(cnt_q) + 32'd1 < GAP_CYC) begin
      state_d = GAP;
    end else begin
      state_d = SHOW;
    end

    if (state_q == SHOW) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = {~disp_dp[dig_q], (lz_blank_c ? SEG_BLANK : hex_code_c)};
    end
  end

  // Pending capture and frame-boundary transfer. A strobe coinciding with
  // the frame end stays pending for the next frame.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      pend_data <= 16'h0000;
      pend_dp   <= 4'h0;
      pend_flag <= 1'b0;
      disp_data <= 16'h0000;
      disp_dp   <= 4'h0;
    end else begin
      if (frame_end_c && pend_flag) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (bus.data_valid) begin
        pend_data <= bus.data_in;
        pend_dp   <= bus.dp_in;
        pend_flag <= 1'b1;
      end else if (frame_end_c) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Four-digit, time-multiplexed seven-segment display driver that sits downstream of the multi-cycle CPU top and drives the board's `AN`/`SEGMENT` pins. It captures a 16-bit hex value and decimal-point mask from the CPU side, then scans the digits one at a time with an anti-ghosting blank gap. New data is applied only at frame boundaries, so a display never shows a torn value.

## Interface
- `SCAN_DIV`, 100000: cycles per digit slot, which is 1 kHz per digit at 100 MHz; must be ≥ 2.
- `GAP_CYC`, 2000: blanked cycles at the start of each slot; must satisfy 0 ≤ GAP_CYC < SCAN_DIV.
- `clk_100mhz`  in  1  system clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  16  hex value; digit k = data_in[4k+3:4k]; digit 0 is rightmost (`AN[0]`).
- `dp_in`  in  4  decimal-point mask, bit k = digit k; 1 = lit.
- `data_valid`  in  1  single-cycle strobe; captures `data_in`/`dp_in` into the pending register.
- `AN`  out  4  digit enables, active-low, registered.
- `SEGMENT`  out  8  {dp,g,f,e,d,c,b,a}, active-low, registered.
- `frame_done`  out  1  one-cycle pulse at the end of digit 3's slot.

## Operation
- Registers: `pend_data`/`pend_dp`/`pend_flag`, `disp_data`/`disp_dp`, slot counter `cnt` (0..SCAN_DIV-1), digit index `dig` (2 bits), state {GAP, SHOW}.
- `data_valid`=1 loads the pending registers and sets `pend_flag`. A later strobe in the same frame overwrites them; the last one wins.
- At the end of a frame (cnt==SCAN_DIV-1 and dig==3), if `pend_flag` is set, copy pending into disp and clear `pend_flag`. A `data_valid` in that same cycle wins: it stays pending with `pend_flag`=1 and is transferred at the next frame.
- FSM per slot: GAP while cnt < GAP_CYC, SHOW otherwise. At cnt==SCAN_DIV-1: cnt←0, dig←dig+1 (wraps 3→0), state←GAP, or SHOW if GAP_CYC==0.
- GAP: AN=4'b1111, SEGMENT=8'hFF.
- SHOW: AN = ~(1<<dig). SEGMENT[6:0] = hex code of disp_data nibble `dig`. SEGMENT[7] = ~disp_dp[dig].
- Hex codes for SEGMENT with dp off:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E

## Timing
- Reset values:
  - AN=4'hF, SEGMENT=8'hFF, frame_done=0
  - cnt=0, dig=0, state=GAP
  - disp_data=0, disp_dp=0, pend_flag=0
- Outputs lag the internal state by one cycle. In slot k, AN goes low at slot-relative cycle GAP_CYC+1 and stays low through slot-relative cycle 0 of slot k+1 inclusive.
- `frame_done` is registered and asserts in the cycle after cnt==SCAN_DIV-1 with dig==3.
- Frame period = 4·SCAN_DIV cycles.
- Strobe-to-display latency is at most 4·SCAN_DIV+GAP_CYC+1 cycles; the new value first appears on digit 0.
- `rst` mid-frame: all state returns to reset values on the next edge; pending data is discarded.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression. Digits 3..1 are blanked (SEGMENT[6:0]=7'h7F) while they and every higher digit are zero. Digit 0 is always shown. The dp still lights if requested. AN still selects the digit.
- Undefined: all four digits are always shown, including leading zeros.

## Structure
- `seg7_pkg`: the 16 segment-code constants, `SEG_BLANK`=7'h7F, and the state enum {GAP, SHOW}.
- Sub-module `seg7_hex_decode`: combinational nibble → 7-bit active-low code.
- The remaining logic stays in `seg7_scan_driver`.

## Test plan
All scenarios use SCAN_DIV=8, GAP_CYC=2.
- Reset, then no strobe for 40 cycles → AN cycles 1110,1101,1011,0111, each low for 6 cycles; SEGMENT=C0 while shown; frame_done pulses every 32 cycles.
- data_valid with data_in=16'h12AF, dp_in=4'b0100 mid-frame → no change until the frame ends; then digit0=8E, digit1=88, digit2=24 (A4 with dp), digit3=F9.
- Two strobes in one frame (16'h1111, then 16'h2222) → only 2222 is displayed in the next frame.
- data_valid in the frame-end cycle → shown after one extra frame; pend_flag set in between.
- `SEG7_LZ_BLANK_EN`, data 16'h0050 → digits 3 and 2 are blank (FF), digit1=92, digit0=C0. Without the macro: C0,C0,92,C0.
- rst asserted mid-SHOW of digit 2 → next cycle AN=F and SEGMENT=FF; the scan restarts at digit 0 with the display cleared to 0000.
